sram_arbiter: RTL and testbench



---
 rtl/sram_arbiter.sv | 152 +++++++++++++++
 tb/tb_sram_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one asynchronous 1Mx16 SRAM between two masters.
// Each access is a fixed-length strobe window followed by a one-cycle ack.
module sram_arbiter #(
  parameter int ADDR_W      = 20,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              Clk,
  input  logic              Reset,

  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,

  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,

  output logic [DATA_W-1:0] rdata,
  output logic              busy,

  output logic              CE,
  output logic              UB,
  output logic              LB,
  output logic              OE,
  output logic              WE,
  output logic [ADDR_W-1:0] ADDR,
  output logic [DATA_W-1:0] Data_to_SRAM,
  input  logic [DATA_W-1:0] Data_from_SRAM,

  output logic [1:0]        state_dbg
);

  // Handshake: a master raises reqN with we/addr/wdata valid and holds it until
  // ackN. Fields are captured on the grant edge only; ackN is a single-cycle
  // completion pulse and the master must drop reqN in that same cycle, otherwise
  // the still-high req counts as a fresh request in the following IDLE cycle.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t      state;
  logic        grant;
  logic        last_grant;
  logic        dir_we;
  logic [3:0]  wait_cnt;

  logic              pick_valid;
  logic              pick;
  logic              pick_we;
  logic [ADDR_W-1:0] pick_addr;
  logic [DATA_W-1:0] pick_wdata;

  // On a tie the port that did not win last time gets the SRAM.
  always_comb begin
    pick_valid = req0 | req1;
    pick       = (req0 & req1) ? ~last_grant : req1;
    pick_we    = pick ? we1    : we0;
    pick_addr  = pick ? addr1  : addr0;
    pick_wdata = pick ? wdata1 : wdata0;
  end

  assign state_dbg = state;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state        <= IDLE;
      grant        <= 1'b0;
      last_grant   <= 1'b1;
      dir_we       <= 1'b0;
      wait_cnt     <= '0;
      CE           <= 1'b1;
      UB           <= 1'b1;
      LB           <= 1'b1;
      OE           <= 1'b1;
      WE           <= 1'b1;
      ADDR         <= '0;
      Data_to_SRAM <= '0;
      rdata        <= '0;
      ack0         <= 1'b0;
      ack1         <= 1'b0;
      busy         <= 1'b0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (pick_valid) begin
            grant        <= pick;
            last_grant   <= pick;
            dir_we       <= pick_we;
            ADDR         <= pick_addr;
            Data_to_SRAM <= pick_wdata;
            wait_cnt     <= WAIT_LOAD;
            CE           <= 1'b0;
            UB           <= 1'b0;
            LB           <= 1'b0;
            OE           <= pick_we;
            WE           <= ~pick_we;
            busy         <= 1'b1;
            state        <= ACCESS;
          end
        end

        ACCESS: begin
          if (wait_cnt == 4'd0) begin
            // Read data is sampled on the last edge the strobes are still low.
            if (!dir_we) begin
              rdata <= Data_from_SRAM;
            end
            CE    <= 1'b1;
            UB    <= 1'b1;
            LB    <= 1'b1;
            OE    <= 1'b1;
            WE    <= 1'b1;
            ack0  <= ~grant;
            ack1  <= grant;
            state <= DONE;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end

        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          CE    <= 1'b1;
          UB    <= 1'b1;
          LB    <= 1'b1;
          OE    <= 1'b1;
          WE    <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed scenarios plus random traffic, all checked
// against a transaction-phase reference model and a behavioural SRAM.
module tb_sram_arbiter;
  localparam int ADDR_W = 20;
  localparam int DATA_W = 16;
  localparam int W      = 2;

  logic              Clk = 1'b0;
  logic              Reset;
  logic              req0, we0, ack0, req1, we1, ack1;
  logic [ADDR_W-1:0] addr0, addr1, ADDR;
  logic [DATA_W-1:0] wdata0, wdata1, rdata, Data_to_SRAM;
  logic [DATA_W-1:0] Data_from_SRAM = '0;
  logic              busy, CE, UB, LB, OE, WE;
  logic [1:0]        state_dbg;

  sram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_CYCLES(W)) dut (
    .Clk(Clk), .Reset(Reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1),
    .rdata(rdata), .busy(busy),
    .CE(CE), .UB(UB), .LB(LB), .OE(OE), .WE(WE), .ADDR(ADDR),
    .Data_to_SRAM(Data_to_SRAM), .Data_from_SRAM(Data_from_SRAM),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 Clk = ~Clk;

  int n_vec = 0;
  int n_err = 0;
  logic chk_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] init_val(input logic [19:0] a);
    return a[15:0] ^ 16'h5A5A;
  endfunction

  // behavioural asynchronous SRAM
  logic [15:0] sram [int];
  always @(negedge Clk) begin
    if (!CE && !WE) sram[int'(ADDR)] = Data_to_SRAM;
    if (!CE && !OE) begin
      if (sram.exists(int'(ADDR))) Data_from_SRAM = sram[int'(ADDR)];
      else Data_from_SRAM = init_val(ADDR);
    end else begin
      Data_from_SRAM = 16'hDEAD;
    end
  end

  // reference model: phase 0 = idle, 1..W = strobe window, W+1 = ack cycle
  logic [15:0] ref_mem [int];
  int          m_phase = 0;
  logic        m_port  = 1'b0;
  logic        m_last  = 1'b1;
  logic        m_we    = 1'b0;
  logic [19:0] m_addr  = '0;
  logic [15:0] m_wdata = '0;
  logic [15:0] m_rdata = '0;

  always @(posedge Clk) begin
    if (m_phase >= 1 && m_phase <= W && m_we) ref_mem[int'(m_addr)] = m_wdata;
    if (Reset) begin
      m_phase = 0; m_last = 1'b1; m_port = 1'b0; m_we = 1'b0;
      m_addr = '0; m_wdata = '0; m_rdata = '0;
    end else if (m_phase == 0) begin
      if (req0 || req1) begin
        m_port  = (req0 && req1) ? !m_last : req1;
        m_last  = m_port;
        m_we    = m_port ? we1 : we0;
        m_addr  = m_port ? addr1 : addr0;
        m_wdata = m_port ? wdata1 : wdata0;
        m_phase = 1;
      end
    end else if (m_phase == W) begin
      if (!m_we) begin
        if (ref_mem.exists(int'(m_addr))) m_rdata = ref_mem[int'(m_addr)];
        else m_rdata = init_val(m_addr);
      end
      m_phase = W + 1;
    end else if (m_phase == W + 1) begin
      m_phase = 0;
    end else begin
      m_phase++;
    end
  end

  // scoreboard: every cycle, compare all outputs with the model
  always @(negedge Clk) begin
    if (chk_en) begin
      check("ctl", {ack0, ack1, busy, CE, UB, LB, OE, WE},
            {(m_phase == W + 1) && !m_port, (m_phase == W + 1) && m_port, m_phase != 0,
             !(m_phase >= 1 && m_phase <= W), !(m_phase >= 1 && m_phase <= W),
             !(m_phase >= 1 && m_phase <= W),
             !(m_phase >= 1 && m_phase <= W && !m_we), !(m_phase >= 1 && m_phase <= W && m_we)});
      check("ADDR", 32'(ADDR), 32'(m_addr));
      check("Data_to_SRAM", 32'(Data_to_SRAM), 32'(m_wdata));
      check("rdata", 32'(rdata), 32'(m_rdata));
    end
  end

  // driver helpers
  task automatic pulse_reset();
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  logic [0:0] exp_q[$];
  logic [0:0] got_q[$];
  int nwe, noe, nack, conc, a0, a1, first;

  initial begin
    Reset = 1'b1; req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
    @(negedge Clk);
    chk_en = 1'b1;
    check("rst_strobes", 32'({CE, UB, LB, OE, WE}), 32'h1f);
    check("rst_ack_busy", 32'({ack0, ack1, busy}), 32'h0);
    check("rst_addr", 32'(ADDR), 32'h0);
    check("rst_rdata", 32'(rdata), 32'h0);
    Reset = 1'b0;

    // port 0 read of 0x00012
    sram[32'h12] = 16'hBEEF; ref_mem[32'h12] = 16'hBEEF;
    req0 = 1; we0 = 0; addr0 = 20'h00012;
    for (int k = 1; k <= 4; k++) begin
      @(negedge Clk);
      if (k <= 2) check("t1_access", 32'({CE, OE, WE, ADDR}), 32'({1'b0, 1'b0, 1'b1, 20'h00012}));
      if (k == 3) begin
        check("t1_ack", 32'({ack0, ack1}), 32'h2);
        check("t1_rdata", 32'(rdata), 32'hBEEF);
        req0 = 0;
      end
      if (k == 4) check("t1_idle", 32'(busy), 32'h0);
    end

    // port 1 write of 0x1234 to 0x0FFFF
    req1 = 1; we1 = 1; addr1 = 20'h0FFFF; wdata1 = 16'h1234;
    nwe = 0; noe = 0; nack = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge Clk);
      if (!WE) begin
        nwe++;
        check("t2_wdata", 32'(Data_to_SRAM), 32'h1234);
      end
      if (!OE) noe++;
      if (ack1) begin nack++; req1 = 0; end
    end
    check("t2_we_cycles", 32'(nwe), 32'd2);
    check("t2_oe_cycles", 32'(noe), 32'd0);
    check("t2_ack_count", 32'(nack), 32'd1);
    check("t2_sram", 32'(sram.exists(32'hFFFF) ? sram[32'hFFFF] : 16'h0), 32'h1234);

    // both ports requesting from reset, each re-raising after its ack
    pulse_reset();
    req0 = 1; we0 = 0; addr0 = 20'h00003; req1 = 1; we1 = 0; addr1 = 20'h00005;
    exp_q = '{1'b0, 1'b1, 1'b0, 1'b1};
    got_q = {}; conc = 0;
    for (int k = 1; k <= 15; k++) begin
      @(negedge Clk);
      if (ack0 && ack1) conc++;
      if (ack0) got_q.push_back(1'b0);
      if (ack1) got_q.push_back(1'b1);
      req0 = !ack0;
      req1 = !ack1;
    end
    req0 = 0; req1 = 0;
    check("t3_grants_in_16", 32'(got_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("t3_grant_order", 32'(i < got_q.size() ? got_q[i] : 1'bx), 32'(exp_q[i]));
    end
    check("t3_concurrent_acks", 32'(conc), 32'd0);
    repeat (4) @(negedge Clk);

    // port 1 holding, port 0 joins mid-access
    pulse_reset();
    req1 = 1; we1 = 0; addr1 = 20'h00007;
    a0 = 0; a1 = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge Clk);
      if (k == 2) begin req0 = 1; we0 = 0; addr0 = 20'h00009; end
      if (ack1 && a1 == 0) a1 = k;
      if (ack0 && a0 == 0) begin a0 = k; req0 = 0; end
    end
    req1 = 0;
    check("t4_ack1_cycle", 32'(a1), 32'd3);
    check("t4_ack0_cycle", 32'(a0), 32'd7);
    repeat (6) @(negedge Clk);

    // reset during cycle 1 of a port 0 write
    pulse_reset();
    req0 = 1; we0 = 1; addr0 = 20'hABCDE; wdata0 = 16'h7777;
    @(negedge Clk);
    check("t5_we_low", 32'(WE), 32'h0);
    Reset = 1; req0 = 0;
    @(negedge Clk);
    check("t5_after_reset", 32'({WE, CE, ack0}), 32'h6);
    Reset = 0;
    nack = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge Clk);
      if (ack0) nack++;
    end
    check("t5_no_ack0", 32'(nack), 32'd0);
    req0 = 1; we0 = 0; addr0 = 20'h00001; req1 = 1; we1 = 0; addr1 = 20'h00002;
    first = 2;
    for (int k = 1; k <= 8; k++) begin
      @(negedge Clk);
      if (first == 2 && ack0) first = 0;
      else if (first == 2 && ack1) first = 1;
      if (ack0) req0 = 0;
      if (ack1) req1 = 0;
    end
    req0 = 0; req1 = 0;
    check("t5_tie_winner", 32'(first), 32'd0);
    repeat (8) @(negedge Clk);

    // req0 dropped and addr0 changed during a read
    sram[32'h40] = 16'hC0DE; ref_mem[32'h40] = 16'hC0DE;
    req0 = 1; we0 = 0; addr0 = 20'h00040;
    for (int k = 1; k <= 4; k++) begin
      @(negedge Clk);
      if (k <= 2) check("t6_addr_held", 32'(ADDR), 32'h40);
      if (k == 1) begin req0 = 0; addr0 = 20'h00777; end
      if (k == 3) begin
        check("t6_ack0", 32'({ack0, ack1}), 32'h2);
        check("t6_rdata", 32'(rdata), 32'hC0DE);
      end
    end

    // random traffic with occasional reset
    for (int c = 0; c < 400; c++) begin
      @(negedge Clk);
      Reset = ($urandom_range(0, 99) == 0);
      if (ack0) req0 = 0;
      else if (!req0) req0 = 1'($urandom_range(0, 1));
      else if ($urandom_range(0, 15) == 0) req0 = 0;
      if (ack1) req1 = 0;
      else if (!req1) req1 = 1'($urandom_range(0, 1));
      else if ($urandom_range(0, 15) == 0) req1 = 0;
      we0 = 1'($urandom_range(0, 1)); addr0 = 20'($urandom_range(0, 15)); wdata0 = 16'($urandom);
      we1 = 1'($urandom_range(0, 1)); addr1 = 20'($urandom_range(0, 15)); wdata1 = 16'($urandom);
    end
    Reset = 0; req0 = 0; req1 = 0;
    repeat (6) @(negedge Clk);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
